// File: rtl/approx_acc_pkg.sv
// Shared types and constants for the approximate dot-product accumulator.
// APPROX_BIAS_COMP_EN selects whether BIAS_COMP is added to every product.
package approx_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Offsets the negative mean error of the upstream approximate multiplier
    localparam logic [15:0] BIAS_COMP = 16'd64;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/approx_sat_add.sv
// Unsigned W-bit saturating adder: clamps to all-ones and flags overflow.
module approx_sat_add
    import approx_acc_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        sum  = full[W] ? '1 : full[W-1:0];
    end

endmodule

// File: rtl/approx_dot_acc.sv
// Accumulates approximate-multiplier products into a saturating dot product.
// Define APPROX_BIAS_COMP_EN to add BIAS_COMP to each product before summing.
module approx_dot_acc
    import approx_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    input  logic             out_ready
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [ACC_W-1:0] term_ext;
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;
    logic             accept;

`ifdef APPROX_BIAS_COMP_EN
    logic [16:0] term;
    assign term = {1'b0, in_prod} + {1'b0, BIAS_COMP};
`else
    logic [15:0] term;
    assign term = in_prod;
`endif

    assign term_ext = ACC_W'(term);

    approx_sat_add #(
        .W(ACC_W)
    ) u_sat_add (
        .a   (acc),
        .b   (term_ext),
        .sum (sum),
        .ovf (ovf)
    );

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        accept    = in_valid & in_ready;
        cnt_full  = &cnt;
        cnt_nxt   = cnt_full ? cnt : cnt + CNT_W'(1);
        sat_nxt   = sat | ovf | cnt_full;
    end

    // Result registers are loaded from the next-state values so the last beat is included
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt_nxt;
                        sat <= sat_nxt;
                        if (in_last) begin
                            state     <= HOLD;
                            out_acc   <= sum;
                            out_count <= cnt_nxt;
                            out_sat   <= sat_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        out_acc   <= '0;
                        out_count <= '0;
                        out_sat   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_dot_acc.sv
// Directed self-checking bench for approx_dot_acc (default and ACC_W=17 instances).
// Expectations follow APPROX_BIAS_COMP_EN when the bench is built with it.
module tb_approx_dot_acc;

`ifdef APPROX_BIAS_COMP_EN
    localparam int unsigned C = 64;
`else
    localparam int unsigned C = 0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_sat;
    logic [23:0] out_acc;
    logic [7:0]  out_count;

    logic        in_ready17, out_valid17, out_sat17;
    logic [16:0] out_acc17;
    logic [7:0]  out_count17;

    int unsigned checks = 0;
    int unsigned errors = 0;

    approx_dot_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_sat   (out_sat),
        .out_ready (out_ready)
    );

    approx_dot_acc #(
        .ACC_W(17)
    ) dut17 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .in_ready  (in_ready17),
        .out_valid (out_valid17),
        .out_acc   (out_acc17),
        .out_count (out_count17),
        .out_sat   (out_sat17),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] p, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_out_acc",   32'(out_acc),   0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_sat",   32'(out_sat),   0);
        rst = 1'b0;

        // Basic three-beat dot product with one-cycle result latency
        beat(16'd1000, 1'b0);
        beat(16'd2000, 1'b0);
        in_valid = 1'b1; in_prod = 16'd3000; in_last = 1'b1;
        check("pre_last_valid", 32'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("basic_valid", 32'(out_valid), 1);
        check("basic_acc",   32'(out_acc),   6000 + 3 * C);
        check("basic_count", 32'(out_count), 3);
        check("basic_sat",   32'(out_sat),   0);
        check("basic_acc17", 32'(out_acc17), 6000 + 3 * C);

        // Hold with backpressure while a new single-beat product waits upstream
        in_valid = 1'b1; in_prod = 16'd5; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid",    32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready),  0);
            check("hold_acc",      32'(out_acc),   6000 + 3 * C);
            check("hold_count",    32'(out_count), 3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_valid",    32'(out_valid), 0);
        check("handoff_in_ready", 32'(in_ready),  1);
        check("handoff_acc",      32'(out_acc),   0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("next_valid", 32'(out_valid), 1);
        check("next_acc",   32'(out_acc),   5 + C);
        check("next_count", 32'(out_count), 1);
        check("next_sat",   32'(out_sat),   0);
        release_result();

        // Accumulator saturation at ACC_W=17
        beat(16'd65535, 1'b0);
        beat(16'd65535, 1'b0);
        beat(16'd65535, 1'b1);
        check("big_acc17",   32'(out_acc17),   131071);
        check("big_sat17",   32'(out_sat17),   1);
        check("big_count17", 32'(out_count17), 3);
        check("big_acc",     32'(out_acc),     196605 + 3 * C);
        check("big_sat",     32'(out_sat),     0);
        release_result();

        // Reset mid-sum, with a beat offered during reset that must be dropped
        beat(16'd1000, 1'b0);
        beat(16'd2000, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_prod = 16'd9; in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("midrst_valid",    32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready),  1);
        check("midrst_acc",      32'(out_acc),   0);
        beat(16'd7, 1'b1);
        check("single_valid", 32'(out_valid), 1);
        check("single_acc",   32'(out_acc),   7 + C);
        check("single_count", 32'(out_count), 1);
        check("single_sat",   32'(out_sat),   0);

        // Reset while holding a result
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("holdrst_valid",    32'(out_valid), 0);
        check("holdrst_in_ready", 32'(in_ready),  1);
        check("holdrst_acc",      32'(out_acc),   0);
        check("holdrst_count",    32'(out_count), 0);

        // Counter saturation: 256 beats into an 8-bit counter
        for (int i = 0; i < 255; i++) beat(16'd1, 1'b0);
        beat(16'd1, 1'b1);
        check("cnt_valid",   32'(out_valid),   1);
        check("cnt_count",   32'(out_count),   255);
        check("cnt_sat",     32'(out_sat),     1);
        check("cnt_acc",     32'(out_acc),     256 + 256 * C);
        check("cnt_acc17",   32'(out_acc17),   256 + 256 * C);
        check("cnt_sat17",   32'(out_sat17),   1);
        release_result();
        check("final_valid", 32'(out_valid), 0);
        check("final_sat",   32'(out_sat),   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
